// File: rtl/cpu_mem_arbiter_if.sv
// cpu_mem_arbiter_if: CPU, DMA and memory command/response signals shared by the arbiter and its environment
interface cpu_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
);
    logic                  c_req, c_we, c_ack;
    logic                  d_req, d_we, d_ack;
    logic [ADDR_WIDTH-1:0] c_addr, d_addr;
    logic [DATA_WIDTH-1:0] c_wdata, d_wdata, c_rdata, d_rdata;
    logic                  mem_req, mem_we, mem_ready;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata, mem_rdata;
    modport slave (
        input  c_req, c_we, c_addr, c_wdata, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        output c_ack, c_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr, mem_wdata
    );
    modport master (
        output c_req, c_we, c_addr, c_wdata, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        input  c_ack, c_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: round-robin CPU/DMA arbiter for a single memory port with access timeout
module cpu_mem_arbiter #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst,
    cpu_mem_arbiter_if.slave   bus,
    output logic               timeout_err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t                state, state_d;
    logic [TW-1:0]         timer;
    logic                  owner, last_dma, pick_d, start, finish;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata, rd_val;
    always_comb begin
        pick_d    = bus.d_req & ~(bus.c_req & last_dma);
        start     = state == IDLE && (bus.c_req || bus.d_req);
        finish    = state == ACCESS && (bus.mem_ready || timer == TW'(TIMEOUT_CYCLES - 1));
        sel_addr  = pick_d ? bus.d_addr : bus.c_addr;
        sel_wdata = pick_d ? bus.d_wdata : bus.c_wdata;
        rd_val    = bus.mem_ready ? bus.mem_rdata : '1;
        state_d   = start ? ACCESS : finish ? DONE : state == DONE ? IDLE : state;
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else      state <= state_d;
    // a timed-out access completes like a read of all-ones, even for writes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.c_ack     <= 1'b0;
            bus.d_ack     <= 1'b0;
            bus.c_rdata   <= '0;
            bus.d_rdata   <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            timer         <= '0;
            owner         <= 1'b0;
            last_dma      <= 1'b1;
            timeout_err   <= 1'b0;
        end else begin
            bus.c_ack <= 1'b0;
            bus.d_ack <= 1'b0;
            if (start) begin
                owner         <= pick_d;
                bus.mem_req   <= 1'b1;
                bus.mem_we    <= pick_d ? bus.d_we : bus.c_we;
                bus.mem_addr  <= sel_addr;
                bus.mem_wdata <= sel_wdata;
                timer         <= '0;
            end
            if (finish) begin
                bus.mem_req <= 1'b0;
                bus.c_ack   <= ~owner;
                bus.d_ack   <= owner;
                last_dma    <= owner;
                if (!bus.mem_ready) timeout_err <= 1'b1;
                if (!bus.mem_ready || !bus.mem_we) begin
                    if (owner) bus.d_rdata <= rd_val;
                    else       bus.c_rdata <= rd_val;
                end
            end else if (state == ACCESS) begin
                timer <= timer + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// tb_cpu_mem_arbiter: vector table, directed corner sequences and random transactions against a transaction-level model
module tb_cpu_mem_arbiter;
    localparam int TO = 16;
    logic clk = 0, rst = 0, timeout_err;
    int tests = 0, fails = 0;
    cpu_mem_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) b ();
    cpu_mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .bus(b.slave), .timeout_err(timeout_err)
    );
    always #5 clk = ~clk;

    typedef struct {
        bit dma; bit we; logic [15:0] addr; logic [7:0] wd;
        int lat; logic [7:0] rd; logic [7:0] exp_rd; bit exp_to;
    } vec_t;

    always @(negedge clk) begin
        tests++;
        if (b.c_ack && b.d_ack) begin
            fails++;
            $display("FAIL ack_exclusive: c_ack=%b d_ack=%b required not both high", b.c_ack, b.d_ack);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic drive(input bit dma, input bit we, input logic [15:0] addr, input logic [7:0] wd);
        if (dma) begin b.d_req = 1; b.d_we = we; b.d_addr = addr; b.d_wdata = wd; end
        else     begin b.c_req = 1; b.c_we = we; b.c_addr = addr; b.c_wdata = wd; end
    endtask

    // Called in an IDLE cycle with the requester's req already high; ready is pulsed lat cycles into ACCESS
    task automatic serve(input bit dma, input bit we, input logic [15:0] addr, input logic [7:0] wd,
                         input int lat, input logic [7:0] rd, input logic [7:0] exp_rd,
                         input bit exp_to, input bit rdy_done);
        int w, k, exp_k;
        bit ok;
        w = 0;
        while (!b.mem_req && w < 40) begin tick(); w++; end
        chk("grant_latency", w, 1);
        chk("mem_we", b.mem_we, we);
        chk("mem_addr", b.mem_addr, addr);
        chk("mem_wdata", b.mem_wdata, wd);
        exp_k = lat < TO ? lat : TO - 1;
        ok = 1;
        k = 0;
        while (k <= TO + 2) begin
            ok &= b.mem_req && b.mem_we == we && b.mem_addr == addr && b.mem_wdata == wd;
            b.mem_ready = (k == lat);
            b.mem_rdata = (k == lat) ? rd : ~rd;
            tick();
            b.mem_ready = 0;
            if (b.c_ack || b.d_ack) break;
            k++;
        end
        chk("ack_cycle", k, exp_k);
        chk("ack_owner", {b.d_ack, b.c_ack}, dma ? 2'b10 : 2'b01);
        chk("rdata", dma ? b.d_rdata : b.c_rdata, exp_rd);
        chk("timeout_err", timeout_err, exp_to);
        chk("mem_req_drop", b.mem_req, 0);
        chk("access_held", ok, 1);
        if (dma) b.d_req = 0; else b.c_req = 0;
        b.mem_ready = rdy_done;
        tick();
        b.mem_ready = 0;
        chk("ack_one_cycle", {b.d_ack, b.c_ack}, 0);
    endtask

    vec_t vt[8];
    bit c_pend, d_pend, last_dma, m_to, own;
    logic [7:0] m_c_rd, m_d_rd, rd, old, exp_rd;
    logic [15:0] c_addr, d_addr;
    logic [7:0] c_wd, d_wd;
    bit c_we, d_we;
    int lat, w;

    initial begin
        vt[0] = '{0, 0, 16'h2329, 8'h00, 2,  8'hA5, 8'hA5, 0};
        vt[1] = '{1, 1, 16'h9001, 8'h5A, 0,  8'h99, 8'h44, 0};
        vt[2] = '{1, 0, 16'h1234, 8'h00, 1,  8'h3C, 8'h3C, 0};
        vt[3] = '{0, 1, 16'h0000, 8'h77, 3,  8'h12, 8'hA5, 0};
        vt[4] = '{0, 0, 16'hFFFF, 8'h00, 15, 8'h00, 8'h00, 0};
        vt[5] = '{1, 0, 16'h8000, 8'h00, 20, 8'h55, 8'hFF, 1};
        vt[6] = '{0, 0, 16'h0001, 8'h00, 0,  8'h5E, 8'h5E, 1};
        vt[7] = '{0, 1, 16'h4321, 8'h66, 16, 8'h01, 8'hFF, 1};
        {b.c_req, b.c_we, b.d_req, b.d_we, b.mem_ready} = '0;
        {b.c_addr, b.d_addr, b.c_wdata, b.d_wdata, b.mem_rdata} = '0;
        repeat (3) tick();
        chk("rst_mem_req", b.mem_req, 0);
        chk("rst_mem_we", b.mem_we, 0);
        chk("rst_mem_addr", b.mem_addr, 0);
        chk("rst_mem_wdata", b.mem_wdata, 0);
        chk("rst_rdata", {b.c_rdata, b.d_rdata}, 0);
        chk("rst_ack", {b.c_ack, b.d_ack}, 0);
        chk("rst_timeout", timeout_err, 0);
        rst = 1;
        tick();

        // simultaneous requests alternate, starting with the CPU after reset
        drive(0, 0, 16'h00C0, 8'h00);
        drive(1, 0, 16'h00D0, 8'h00);
        serve(0, 0, 16'h00C0, 8'h00, 0, 8'h11, 8'h11, 0, 0);
        drive(0, 0, 16'h00C1, 8'h00);
        serve(1, 0, 16'h00D0, 8'h00, 1, 8'h22, 8'h22, 0, 0);
        drive(1, 0, 16'h00D1, 8'h00);
        serve(0, 0, 16'h00C1, 8'h00, 0, 8'h33, 8'h33, 0, 0);
        serve(1, 0, 16'h00D1, 8'h00, 2, 8'h44, 8'h44, 0, 0);

        for (int i = 0; i < 8; i++) begin
            drive(vt[i].dma, vt[i].we, vt[i].addr, vt[i].wd);
            serve(vt[i].dma, vt[i].we, vt[i].addr, vt[i].wd, vt[i].lat, vt[i].rd,
                  vt[i].exp_rd, vt[i].exp_to, 0);
        end

        // mem_ready outside ACCESS must be ignored
        b.mem_ready = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_ready_req", b.mem_req, 0);
            chk("idle_ready_ack", {b.c_ack, b.d_ack}, 0);
        end
        b.mem_ready = 0;
        drive(0, 0, 16'h0D0E, 8'h00);
        serve(0, 0, 16'h0D0E, 8'h00, 0, 8'h61, 8'h61, 1, 1);
        tick();
        chk("done_ready_req", b.mem_req, 0);
        chk("done_ready_ack", {b.c_ack, b.d_ack}, 0);

        // reset in the middle of an access abandons it silently
        drive(0, 0, 16'h4444, 8'h00);
        w = 0;
        while (!b.mem_req && w < 10) begin tick(); w++; end
        chk("pre_rst_grant", b.mem_req, 1);
        tick();
        rst = 0;
        #1;
        chk("mid_rst_mem_req", b.mem_req, 0);
        chk("mid_rst_mem_addr", b.mem_addr, 0);
        chk("mid_rst_c_rdata", b.c_rdata, 0);
        chk("mid_rst_timeout", timeout_err, 0);
        chk("mid_rst_ack", {b.c_ack, b.d_ack}, 0);
        tick();
        tick();
        chk("rst_hold_ack", {b.c_ack, b.d_ack}, 0);
        rst = 1;
        serve(0, 0, 16'h4444, 8'h00, 1, 8'h9C, 8'h9C, 0, 0);

        last_dma = 0; m_c_rd = 8'h9C; m_d_rd = 8'h00; m_to = 0; c_pend = 0; d_pend = 0;
        for (int i = 0; i < 60; i++) begin
            if (!c_pend && $urandom_range(0, 1)) begin
                c_pend = 1; c_we = 1'($urandom); c_addr = 16'($urandom); c_wd = 8'($urandom);
                drive(0, c_we, c_addr, c_wd);
            end
            if (!d_pend && ($urandom_range(0, 1) || !c_pend)) begin
                d_pend = 1; d_we = 1'($urandom); d_addr = 16'($urandom); d_wd = 8'($urandom);
                drive(1, d_we, d_addr, d_wd);
            end
            own = (c_pend && d_pend) ? !last_dma : d_pend;
            lat = ($urandom_range(0, 3) == 0) ? $urandom_range(TO - 1, TO + 1) : $urandom_range(0, 3);
            rd  = 8'($urandom);
            old = own ? m_d_rd : m_c_rd;
            exp_rd = lat >= TO ? 8'hFF : ((own ? d_we : c_we) ? old : rd);
            if (lat >= TO) m_to = 1;
            if (own) m_d_rd = exp_rd; else m_c_rd = exp_rd;
            if (own) serve(1, d_we, d_addr, d_wd, lat, rd, exp_rd, m_to, 0);
            else     serve(0, c_we, c_addr, c_wd, lat, rd, exp_rd, m_to, 0);
            if (own) d_pend = 0; else c_pend = 0;
            last_dma = own;
            chk("rand_other_rdata", own ? b.c_rdata : b.d_rdata, own ? m_c_rd : m_d_rd);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cpu_mem_arbiter.md
CPU_MEM_ARBITER -- requirements
Module: cpu_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, meaning address width of all ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning data width of all ports.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning maximum ACCESS cycles before abort.
REQ-004 SHALL have port clk, input, 1, the only clock; all state changes on rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous, active-low reset.
REQ-006 SHALL have ports c_req / d_req, input, 1, CPU / DMA access request.
REQ-007 SHALL have ports c_we / d_we, input, 1, access direction: 0 = read, 1 = write.
REQ-008 SHALL have ports c_addr / d_addr, input, ADDR_WIDTH, requester address.
REQ-009 SHALL have ports c_wdata / d_wdata, input, DATA_WIDTH, requester write data.
REQ-010 SHALL have ports c_ack / d_ack, output, 1, one-cycle completion pulse.
REQ-011 SHALL have ports c_rdata / d_rdata, output, DATA_WIDTH, read result.
REQ-012 SHALL have ports mem_req, mem_we, mem_addr and mem_wdata as outputs (1, 1, ADDR_WIDTH, DATA_WIDTH), forming the registered memory command.
REQ-013 SHALL have port mem_rdata, input, DATA_WIDTH, memory read data.
REQ-014 SHALL have port mem_ready, input, 1, memory completion strobe.
REQ-015 SHALL have port timeout_err, output, 1, sticky flag set when an access times out.

Function
REQ-016 SHALL implement three states: IDLE, ACCESS and DONE.
REQ-017 IDLE SHALL sample requests:
- no request: stay in IDLE.
- exactly one request: grant that requester.
- both requesting: grant the requester not served last (round-robin).
REQ-018 On grant, SHALL register owner, we, addr and wdata into the mem_* outputs, drive mem_req=1 and enter ACCESS in the same edge, so mem_req rises 1 cycle after req is first seen in IDLE.
REQ-019 In ACCESS, SHALL hold mem_req and all mem_* fields stable and increment a timer that starts at 0.
REQ-020 In ACCESS with mem_ready=1, SHALL:
- drop mem_req.
- for a read, load mem_rdata into the owner's rdata register; for a write, leave rdata unchanged.
- assert the owner's ack.
- record the owner as last-served.
- enter DONE.
REQ-021 In ACCESS, if the timer reaches TIMEOUT_CYCLES-1 with mem_ready=0, SHALL drop mem_req, load the owner's rdata with all-ones, assert the owner's ack, set timeout_err, record last-served and enter DONE.
REQ-022 mem_ready in the same cycle as the timeout limit SHALL count as success; timeout_err stays unchanged.
REQ-023 In DONE, ack SHALL be high for exactly that one cycle; requests SHALL be ignored; the next state is IDLE.
REQ-024 Requesters SHALL hold req and fields stable until ack and may drop req in the DONE cycle; a req still high in IDLE is a new access.
REQ-025 A non-owner's request SHALL wait without loss while the other access is in progress.
REQ-026 mem_ready SHALL be ignored outside ACCESS.
REQ-027 c_ack and d_ack SHALL never be high simultaneously.
REQ-028 Minimum access cost SHALL be 3 cycles per transaction (grant, ACCESS with immediate ready, DONE).

Reset
REQ-029 rst low SHALL immediately set state=IDLE, all ack/mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, c_rdata/d_rdata=0, timer=0, timeout_err=0 and last-served=DMA, so the CPU wins the first tie.
REQ-030 Reset asserted during ACCESS SHALL abandon the access with no ack; timeout_err SHALL clear only on reset.

Verification
REQ-031 CPU read, addr 16'h2329, mem_rdata 8'hA5 with mem_ready 2 cycles after mem_req -> mem_addr=2329, mem_we=0, c_ack one cycle, c_rdata=A5, d_ack never high.
REQ-032 c_req and d_req rise together after reset -> CPU served first; DMA mem_req rises 1 cycle after CPU DONE; the next simultaneous pair is served DMA first.
REQ-033 DMA write, addr 16'h9001, wdata 8'h5A -> mem_we=1, mem_wdata=5A held through ACCESS; d_rdata unchanged after d_ack.
REQ-034 CPU read with mem_ready never asserted -> c_ack after TIMEOUT_CYCLES ACCESS cycles, c_rdata=FF, timeout_err=1 and held through later successful accesses.
REQ-035 rst pulsed low mid-ACCESS -> outputs at reset values immediately, no ack, next request granted normally.
REQ-036 mem_ready pulsed during IDLE and DONE -> no state change and no ack.
